// File: rtl/ltpi_data_channel_controller_mm_v2.sv
// ltpi_data_channel_controller_mm_v2
// Bridges a single-outstanding Avalon-MM slave onto the LTPI data channel.
// A command is captured in IDLE, pushed to the data-channel FIFO (REQ) and
// the controller then waits for the tagged completion (WAIT). CRC errors and
// timeouts are retried up to MAX_RETRY times with the same tag and payload.
// Ports:
//   clk, reset (async, active-high), data_channel_rst (sync abort/flush)
//   Avalon slave: chipselect/read/write/address/byteenable/writedata in,
//                 waitrequest/readdatavalid/writeresponsevalid/readdata/response out
//   req_valid/req_ack/req       : request to the data-channel FIFO
//   resp_valid/resp             : completions from the data channel
//   timeout_cnt/crc_err_cnt/unexp_cnt : saturating 8-bit status counters

package ltpi_dc_pkg;
    localparam logic [3:0] READ_REQ   = 4'h0;
    localparam logic [3:0] WRITE_REQ  = 4'h1;
    localparam logic [3:0] READ_COMP  = 4'h2;
    localparam logic [3:0] WRITE_COMP = 4'h3;
    localparam logic [3:0] CRC_ERROR  = 4'h4;

    typedef struct packed {
        logic [7:0]  tag;
        logic [3:0]  command;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  byte_en;
        logic [3:0]  operation_status;
    } Data_channel_payload_t;
endpackage

module ltpi_data_channel_controller_mm_v2
    import ltpi_dc_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int MAX_RETRY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_channel_rst,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [3:0]            byteenable,
    input  logic [31:0]           writedata,
    output logic                  waitrequest,
    output logic                  readdatavalid,
    output logic                  writeresponsevalid,
    output logic [31:0]           readdata,
    output logic [1:0]            response,
    output logic                  req_valid,
    input  logic                  req_ack,
    output Data_channel_payload_t req,
    input  logic                  resp_valid,
    input  Data_channel_payload_t resp,
    output logic [7:0]            timeout_cnt,
    output logic [7:0]            crc_err_cnt,
    output logic [7:0]            unexp_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                state_q, state_d;
    logic                  busy_q;
    logic                  req_valid_q, req_valid_d;
    Data_channel_payload_t req_q, req_d;
    logic                  rnw_q, rnw_d;
    logic [7:0]            tag_q, tag_d;
    logic [2:0]            retry_q, retry_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  rdv_q, rdv_d, wrv_q, wrv_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            response_q, response_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d, crc_cnt_q, crc_cnt_d, unexp_cnt_q, unexp_cnt_d;

    logic        accept, tag_hit, match_ok, match_crc, timeout;
    logic        done;
    logic [1:0]  done_resp;
    logic [31:0] done_data;
    logic        unused_resp;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign waitrequest        = busy_q | data_channel_rst;
    assign req_valid          = req_valid_q;
    assign req                = req_q;
    assign readdatavalid      = rdv_q;
    assign writeresponsevalid = wrv_q;
    assign readdata           = rdata_q;
    assign response           = response_q;
    assign timeout_cnt        = tmo_cnt_q;
    assign crc_err_cnt        = crc_cnt_q;
    assign unexp_cnt          = unexp_cnt_q;
    assign unused_resp        = ^{resp.address, resp.byte_en};

    assign accept = (state_q == IDLE) && chipselect && (read || write) && !waitrequest;

    // A channel abort takes precedence, so nothing arriving in that cycle
    // is treated as a completion of the in-flight transaction.
    assign tag_hit   = resp_valid && (state_q == WAIT) && !data_channel_rst && (resp.tag == tag_q);
    assign match_ok  = tag_hit && (resp.command == (rnw_q ? READ_COMP : WRITE_COMP));
    assign match_crc = tag_hit && (resp.command == CRC_ERROR);
    // Any matching completion beats a timeout landing in the same cycle.
    assign timeout   = (state_q == WAIT) && !data_channel_rst && (timer_q == TW'(TIMEOUT_CYCLES - 1))
                       && !(match_ok || match_crc);

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_d       = req_q;
        rnw_d       = rnw_q;
        tag_d       = tag_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        rdv_d       = 1'b0;
        wrv_d       = 1'b0;
        rdata_d     = '0;
        response_d  = 2'b00;
        tmo_cnt_d   = tmo_cnt_q;
        crc_cnt_d   = crc_cnt_q;
        unexp_cnt_d = unexp_cnt_q;
        done        = 1'b0;
        done_resp   = 2'b10;
        done_data   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d                = REQ;
                    req_valid_d            = 1'b1;
                    rnw_d                  = !write;
                    retry_d                = '0;
                    req_d.tag              = tag_q;
                    req_d.command          = write ? WRITE_REQ : READ_REQ;
                    req_d.address          = 32'(address);
                    req_d.data             = write ? (writedata & byte_mask(byteenable)) : 32'h0;
                    req_d.byte_en          = byteenable;
                    req_d.operation_status = 4'hF;
                end
            end
            REQ: begin
                if (data_channel_rst) begin
                    done = 1'b1;
                end else if (req_ack) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                    timer_d     = '0;
                end
            end
            WAIT: begin
                if (data_channel_rst) begin
                    done = 1'b1;
                end else if (match_ok) begin
                    done      = 1'b1;
                    done_resp = (resp.operation_status == 4'h0) ? 2'b00 : 2'b10;
                    done_data = resp.data & byte_mask(req_q.byte_en);
                end else if (match_crc || timeout) begin
                    if (retry_q != 3'(MAX_RETRY)) begin
                        retry_d     = retry_q + 3'd1;
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Every completion (good, failed or aborted) retires the tag.
        if (done) begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
            rdv_d       = rnw_q;
            wrv_d       = !rnw_q;
            response_d  = done_resp;
            rdata_d     = rnw_q ? done_data : 32'h0;
            tag_d       = tag_q + 8'd1;
            retry_d     = '0;
            timer_d     = '0;
        end

        if (timeout && (tmo_cnt_q != 8'hFF))                     tmo_cnt_d   = tmo_cnt_q + 8'd1;
        if (match_crc && (crc_cnt_q != 8'hFF))                   crc_cnt_d   = crc_cnt_q + 8'd1;
        if (resp_valid && !(match_ok || match_crc) && (unexp_cnt_q != 8'hFF))
                                                                 unexp_cnt_d = unexp_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            rnw_q       <= 1'b1;
            tag_q       <= '0;
            retry_q     <= '0;
            timer_q     <= '0;
            rdv_q       <= 1'b0;
            wrv_q       <= 1'b0;
            rdata_q     <= '0;
            response_q  <= 2'b00;
            tmo_cnt_q   <= '0;
            crc_cnt_q   <= '0;
            unexp_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            rnw_q       <= rnw_d;
            tag_q       <= tag_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            rdv_q       <= rdv_d;
            wrv_q       <= wrv_d;
            rdata_q     <= rdata_d;
            response_q  <= response_d;
            tmo_cnt_q   <= tmo_cnt_d;
            crc_cnt_q   <= crc_cnt_d;
            unexp_cnt_q <= unexp_cnt_d;
        end
    end

endmodule

// File: tb/tb_ltpi_data_channel_controller_mm_v2.sv
// Self-checking bench for ltpi_data_channel_controller_mm_v2 (TIMEOUT_CYCLES=16,
// MAX_RETRY=2). Expected values come from a transaction-level model: a tag
// counter, masked-data arithmetic and event counters kept by the bench.
module tb_ltpi_data_channel_controller_mm_v2;
    import ltpi_dc_pkg::*;

    localparam int TMO = 16;
    localparam int MR  = 2;

    logic clk = 1'b0;
    logic reset, data_channel_rst, chipselect, read, write;
    logic [31:0] address, writedata;
    logic [3:0]  byteenable;
    logic waitrequest, readdatavalid, writeresponsevalid;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic req_valid, req_ack, resp_valid;
    Data_channel_payload_t req, resp;
    logic [7:0] timeout_cnt, crc_err_cnt, unexp_cnt;

    int checks = 0, failures = 0;
    logic [7:0] m_tag = 8'd0;
    int m_tmo = 0, m_crc = 0, m_unexp = 0, hs_cnt = 0;

    ltpi_data_channel_controller_mm_v2 #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .data_channel_rst(data_channel_rst),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
        .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
        .readdata(readdata), .response(response), .req_valid(req_valid),
        .req_ack(req_ack), .req(req), .resp_valid(resp_valid), .resp(resp),
        .timeout_cnt(timeout_cnt), .crc_err_cnt(crc_err_cnt), .unexp_cnt(unexp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send_resp(input logic [3:0] cmd, input logic [7:0] tag, input logic [3:0] st,
                             input logic [31:0] d);
        resp = '0; resp.tag = tag; resp.command = cmd; resp.operation_status = st; resp.data = d;
        resp_valid = 1'b1;
        tick;
        resp_valid = 1'b0; resp = '0;
    endtask

    // Waits for a request, checks its payload, holds off ack a random time, then acks.
    task automatic handshake(input bit rnw, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
        Data_channel_payload_t exp;
        int n = 0;
        int d;
        exp.tag = m_tag; exp.command = rnw ? READ_REQ : WRITE_REQ; exp.address = addr;
        exp.data = rnw ? 32'h0 : (wd & lane_mask(be)); exp.byte_en = be; exp.operation_status = 4'hF;
        while (req_valid !== 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if (req_valid !== 1'b1) begin failures++; $display("FAIL req_valid_wait got=%b want=1", req_valid); end
        checks++;
        if (req !== exp) begin failures++; $display("FAIL req_payload got=%h want=%h", req, exp); end
        d = $urandom_range(0, 2);
        repeat (d) tick;
        checks++;
        if (req_valid !== 1'b1 || req !== exp) begin
            failures++; $display("FAIL req_hold got=%b/%h want=1/%h", req_valid, req, exp);
        end
        req_ack = 1'b1; tick; req_ack = 1'b0; hs_cnt++;
        checks++;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL req_drop got=%b want=0", req_valid); end
    endtask

    task automatic issue(input bit rnw, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        chipselect = 1'b1; read = rnw; write = !rnw; address = addr; byteenable = be; writedata = wd;
        checks++;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL accept_waitreq got=%b want=0", waitrequest); end
        tick;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        handshake(rnw, addr, be, wd);
    endtask

    // Called the cycle after the completing event: the response pulse must be visible now.
    task automatic finish_txn(input string nm, input bit rnw, input logic [1:0] er, input logic [31:0] erd);
        checks++;
        if (readdatavalid !== rnw || writeresponsevalid !== !rnw || response !== er || readdata !== erd) begin
            failures++;
            $display("FAIL %s pulse got rdv=%b wrv=%b resp=%b rd=%h want rdv=%b wrv=%b resp=%b rd=%h",
                     nm, readdatavalid, writeresponsevalid, response, readdata, rnw, !rnw, er, erd);
        end
        m_tag = m_tag + 8'd1;
        tick;
        checks++;
        if (readdatavalid !== 1'b0 || writeresponsevalid !== 1'b0 || readdata !== 32'h0 || waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL %s after_pulse got rdv=%b wrv=%b rd=%h wr=%b want 0", nm, readdatavalid,
                     writeresponsevalid, readdata, waitrequest);
        end
    endtask

    task automatic test_reset;
        Data_channel_payload_t z;
        z = '0; z.command = READ_REQ;
        reset = 1'b1; data_channel_rst = 0; chipselect = 0; read = 0; write = 0;
        address = 0; byteenable = 0; writedata = 0; req_ack = 0; resp_valid = 0; resp = '0;
        tick; tick;
        reset = 1'b0; tick;
        checks++; if (waitrequest !== 1'b0) begin failures++; $display("FAIL rst_waitreq got=%b want=0", waitrequest); end
        checks++; if (readdatavalid !== 1'b0 || writeresponsevalid !== 1'b0) begin
            failures++; $display("FAIL rst_pulses got=%b%b want=00", readdatavalid, writeresponsevalid); end
        checks++; if (readdata !== 32'h0 || response !== 2'b00) begin
            failures++; $display("FAIL rst_data got=%h/%b want=0/00", readdata, response); end
        checks++; if (req_valid !== 1'b0 || req !== z) begin
            failures++; $display("FAIL rst_req got=%b/%h want=0/%h", req_valid, req, z); end
        checks++; if ({timeout_cnt, crc_err_cnt, unexp_cnt} !== 24'h0) begin
            failures++; $display("FAIL rst_counters got=%h want=0", {timeout_cnt, crc_err_cnt, unexp_cnt}); end
    endtask

    task automatic test_write_directed;
        issue(1'b0, 32'h0001_2340, 4'b0101, 32'hAABBCCDD);
        checks++; if (req.data !== 32'h00BB00DD) begin failures++; $display("FAIL wr_lane_zero got=%h want=00bb00dd", req.data); end
        send_resp(WRITE_COMP, m_tag, 4'h0, 32'h0);
        finish_txn("wr_directed", 1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_read_directed;
        checks++; if (m_tag !== 8'd1) begin failures++; $display("FAIL model_tag got=%0d want=1", m_tag); end
        issue(1'b1, 32'h8000_0010, 4'hF, $urandom);
        send_resp(READ_COMP, m_tag, 4'h0, 32'h12345678);
        finish_txn("rd_directed", 1'b1, 2'b00, 32'h12345678);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            bit rnw = $urandom_range(0, 1);
            logic [31:0] a = $urandom, wd = $urandom, rd = $urandom;
            logic [3:0] be = 4'($urandom);
            logic [3:0] st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue(rnw, a, be, wd);
            if ($urandom_range(0, 2) == 0) begin
                send_resp(rnw ? READ_COMP : WRITE_COMP, m_tag + 8'd1, 4'h0, rd);
                m_unexp++;
                checks++;
                if (waitrequest !== 1'b1 || readdatavalid !== 1'b0 || writeresponsevalid !== 1'b0) begin
                    failures++; $display("FAIL rnd_stray got wr=%b rdv=%b wrv=%b want 1/0/0", waitrequest,
                                         readdatavalid, writeresponsevalid);
                end
            end
            send_resp(rnw ? READ_COMP : WRITE_COMP, m_tag, st, rd);
            finish_txn("rnd", rnw, (st == 4'h0) ? 2'b00 : 2'b10, rnw ? (rd & lane_mask(be)) : 32'h0);
        end
        checks++; if (unexp_cnt !== 8'(m_unexp)) begin failures++; $display("FAIL rnd_unexp got=%0d want=%0d", unexp_cnt, m_unexp); end
    endtask

    task automatic test_crc_retry;
        int hs0 = hs_cnt;
        logic [31:0] a = $urandom;
        issue(1'b1, a, 4'hF, 32'h0);
        for (int k = 0; k <= MR; k++) begin
            send_resp(CRC_ERROR, m_tag, 4'h0, 32'hDEAD_BEEF);
            m_crc++;
            if (k < MR) handshake(1'b1, a, 4'hF, 32'h0);
        end
        finish_txn("crc_exhaust", 1'b1, 2'b10, 32'h0);
        checks++; if (hs_cnt - hs0 !== MR + 1) begin failures++; $display("FAIL crc_handshakes got=%0d want=%0d", hs_cnt - hs0, MR + 1); end
        checks++; if (crc_err_cnt !== 8'(m_crc)) begin failures++; $display("FAIL crc_cnt got=%0d want=%0d", crc_err_cnt, m_crc); end
        // One CRC error followed by a good completion recovers.
        issue(1'b0, a, 4'b1100, 32'h11223344);
        send_resp(CRC_ERROR, m_tag, 4'h0, 32'h0); m_crc++;
        handshake(1'b0, a, 4'b1100, 32'h11223344);
        send_resp(WRITE_COMP, m_tag, 4'h0, 32'h0);
        finish_txn("crc_recover", 1'b0, 2'b00, 32'h0);
        checks++; if (crc_err_cnt !== 8'(m_crc)) begin failures++; $display("FAIL crc_cnt2 got=%0d want=%0d", crc_err_cnt, m_crc); end
    endtask

    task automatic test_timeout;
        logic [31:0] a = $urandom;
        issue(1'b0, a, 4'hF, 32'hCAFE_F00D);
        for (int k = 0; k <= MR; k++) begin
            repeat (TMO - 1) tick;
            checks++;
            if (writeresponsevalid !== 1'b0 || req_valid !== 1'b0 || waitrequest !== 1'b1) begin
                failures++; $display("FAIL tmo_early k=%0d got wrv=%b rv=%b wr=%b want 0/0/1", k,
                                     writeresponsevalid, req_valid, waitrequest);
            end
            tick;
            m_tmo++;
            if (k < MR) handshake(1'b0, a, 4'hF, 32'hCAFE_F00D);
        end
        finish_txn("tmo_exhaust", 1'b0, 2'b10, 32'h0);
        checks++; if (timeout_cnt !== 8'(m_tmo)) begin failures++; $display("FAIL tmo_cnt got=%0d want=%0d", timeout_cnt, m_tmo); end
        // Completion in the last WAIT cycle beats the timeout.
        issue(1'b1, a, 4'b0011, 32'h0);
        repeat (TMO - 1) tick;
        send_resp(READ_COMP, m_tag, 4'h0, 32'h89AB_CDEF);
        finish_txn("tmo_edge", 1'b1, 2'b00, 32'h0000_CDEF);
        checks++; if (timeout_cnt !== 8'(m_tmo)) begin failures++; $display("FAIL tmo_edge_cnt got=%0d want=%0d", timeout_cnt, m_tmo); end
    endtask

    task automatic test_unexpected;
        issue(1'b1, 32'h0000_0040, 4'hF, 32'h0);
        send_resp(READ_COMP, m_tag + 8'd1, 4'h0, 32'h5555_5555); m_unexp++;
        send_resp(WRITE_COMP, m_tag, 4'h0, 32'h6666_6666);        m_unexp++;
        checks++;
        if (waitrequest !== 1'b1 || readdatavalid !== 1'b0 || unexp_cnt !== 8'(m_unexp)) begin
            failures++; $display("FAIL unexp_pending got wr=%b rdv=%b cnt=%0d want 1/0/%0d", waitrequest,
                                 readdatavalid, unexp_cnt, m_unexp);
        end
        send_resp(READ_COMP, m_tag, 4'h0, 32'h7777_7777);
        finish_txn("unexp_then_ok", 1'b1, 2'b00, 32'h7777_7777);
        send_resp(READ_COMP, m_tag, 4'h0, 32'h1); m_unexp++;
        checks++;
        if (readdatavalid !== 1'b0 || unexp_cnt !== 8'(m_unexp)) begin
            failures++; $display("FAIL unexp_idle got rdv=%b cnt=%0d want 0/%0d", readdatavalid, unexp_cnt, m_unexp);
        end
    endtask

    task automatic test_dc_rst;
        issue(1'b0, 32'h0000_1000, 4'hF, 32'h1234_0000);
        tick;
        data_channel_rst = 1'b1; #1;
        checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL dcr_waitreq got=%b want=1", waitrequest); end
        tick;
        data_channel_rst = 1'b0;
        finish_txn("dcr_abort", 1'b0, 2'b10, 32'h0);
        send_resp(WRITE_COMP, m_tag - 8'd1, 4'h0, 32'h0); m_unexp++;
        checks++; if (unexp_cnt !== 8'(m_unexp)) begin failures++; $display("FAIL dcr_late got=%0d want=%0d", unexp_cnt, m_unexp); end
        // Abort held in IDLE blocks acceptance.
        data_channel_rst = 1'b1; chipselect = 1'b1; write = 1'b1; #1;
        checks++; if (waitrequest !== 1'b1) begin failures++; $display("FAIL dcr_idle_wr got=%b want=1", waitrequest); end
        tick;
        data_channel_rst = 1'b0; chipselect = 1'b0; write = 1'b0;
        tick;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL dcr_idle_accept got=%b want=0", req_valid); end
    endtask

    task automatic test_tag_wrap;
        while (m_tag != 8'd0) begin
            issue(1'b0, $urandom, 4'hF, $urandom);
            send_resp(WRITE_COMP, m_tag, 4'h0, 32'h0);
            finish_txn("wrap_fill", 1'b0, 2'b00, 32'h0);
        end
        issue(1'b1, 32'h0000_0004, 4'hF, 32'h0);
        checks++; if (req.tag !== 8'h00) begin failures++; $display("FAIL tag_wrap got=%h want=00", req.tag); end
        send_resp(READ_COMP, m_tag, 4'h0, 32'hA5A5_A5A5);
        finish_txn("wrap_done", 1'b1, 2'b00, 32'hA5A5_A5A5);
    endtask

    initial begin
        test_reset;
        test_write_directed;
        test_read_directed;
        test_random;
        test_crc_retry;
        test_timeout;
        test_unexpected;
        test_dc_rst;
        test_tag_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ltpi_data_channel_controller_mm_v2.md
LTPI_DATA_CHANNEL_CONTROLLER_MM_V2 -- requirements
Module: ltpi_data_channel_controller_mm_v2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning Avalon/request address width, 16..32.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 60000, meaning completion timeout in clk cycles, >=2.
REQ-003 SHALL have parameter MAX_RETRY, default 2, meaning re-issues after CRC_ERROR/timeout before failing, 0..7.
REQ-004 SHALL have port clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port data_channel_rst  in  1  synchronous channel abort/flush.
REQ-007 SHALL have Avalon slave ports chipselect, read, write (in, 1 each); address (in, ADDR_W); byteenable (in, 4); writedata (in, 32).
REQ-008 SHALL have Avalon slave ports waitrequest, readdatavalid, writeresponsevalid (out, 1 each); readdata (out, 32); response (out, 2).
REQ-009 SHALL have ports req_valid (out, 1), req_ack (in, 1), req (out, Data_channel_payload_t): request to data-channel FIFO.
REQ-010 SHALL have ports resp_valid (in, 1), resp (in, Data_channel_payload_t): completions from data channel.
REQ-011 SHALL have status ports timeout_cnt, crc_err_cnt, unexp_cnt (out, 8 each), saturating at 255.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT; a one-cycle response pulse accompanies the WAIT->IDLE transition.
REQ-013 SHALL drive waitrequest = busy_q OR data_channel_rst; busy_q is 0 only in IDLE.
REQ-014 SHALL accept a command in IDLE when chipselect & (read|write) & !waitrequest; write has priority if both set; captures full ADDR_W address for reads and writes, byteenable, rnw.
REQ-015 SHALL zero writedata byte lanes whose byteenable bit is 0 when capturing write data.
REQ-016 SHALL enter REQ the cycle after acceptance, drive req_valid=1, req.tag=tag_q, req.command=WRITE_REQ/READ_REQ, req.address, req.data (0 for reads), req.byte_en, req.operation_status=4'hF.
REQ-017 SHALL hold req_valid and req stable until req_ack=1; on req_ack, deassert req_valid next cycle and enter WAIT with timer cleared to 0.
REQ-018 SHALL treat a completion as matching only when resp_valid=1, state WAIT, resp.tag==tag_q and command is WRITE_COMP (write) / READ_COMP (read) / CRC_ERROR (either).
REQ-019 SHALL, on matching READ_COMP/WRITE_COMP, next cycle pulse readdatavalid or writeresponsevalid for 1 cycle, response=2'b00 if resp.operation_status==0 else 2'b10, drop busy_q, return to IDLE.
REQ-020 SHALL drive readdata with resp.data masked by captured byteenable during the readdatavalid pulse, else readdata=0.
REQ-021 SHALL count WAIT cycles; timeout fires when count reaches TIMEOUT_CYCLES-1 with no matching completion in that cycle.
REQ-022 SHALL, on matching CRC_ERROR or timeout with retry_cnt<MAX_RETRY, increment retry_cnt and re-enter REQ with identical payload and tag.
REQ-023 SHALL, on CRC_ERROR or timeout with retry_cnt==MAX_RETRY, complete with response=2'b10 (readdata=0 for reads) per REQ-019 timing.
REQ-024 SHALL increment crc_err_cnt per matching CRC_ERROR and timeout_cnt per timeout, including retried ones.
REQ-025 SHALL drop any other resp_valid (tag mismatch, wrong command, state IDLE/REQ) with no state change, incrementing unexp_cnt.
REQ-026 SHALL increment tag_q modulo 256 (255 wraps to 0) after every completed transaction, successful or failed; clear retry_cnt.
REQ-027 SHALL give a matching completion priority over a timeout occurring in the same cycle.
REQ-028 SHALL, on data_channel_rst in REQ or WAIT, deassert req_valid next cycle and complete the in-flight transaction with response=2'b10 per REQ-019/REQ-026; in IDLE, no command is accepted.

Reset
REQ-029 SHALL, on reset, set state IDLE, waitrequest=0 (absent data_channel_rst), readdatavalid=0, writeresponsevalid=0, readdata=0, response=0, req_valid=0, req all-zero with command=READ_REQ, tag_q=0, retry_cnt=0, timer=0, all status counters 0.

Verification
REQ-030 Write addr=0x0001_2340, be=4'b0101, wdata=0xAABBCCDD, ack immediate, WRITE_COMP tag 0 status 0 -> req.data=0x00BB00DD, writeresponsevalid 1 cycle, response=00, tag_q=1.
REQ-031 Read addr=0x8000_0010 (ADDR_W=32), be=4'hF, READ_COMP data 0x12345678 -> req.address=0x8000_0010, readdata=0x12345678 with readdatavalid, response=00.
REQ-032 MAX_RETRY=2, three CRC_ERROR responses -> exactly 3 req_valid handshakes same tag, then response=10, crc_err_cnt=3.
REQ-033 TIMEOUT_CYCLES=16, MAX_RETRY=0, no response -> completion 16 cycles after WAIT entry plus 1, response=10, timeout_cnt=1; matching resp in cycle 15 instead -> response=00, timeout_cnt=0.
REQ-034 READ_COMP with tag_q+1 during WAIT -> ignored, unexp_cnt=1, transaction still pending; 256 transactions -> tag wraps to 0.
REQ-035 data_channel_rst asserted mid-WAIT -> waitrequest high that cycle, response=10 pulse next cycle, late completion counted in unexp_cnt.
